// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and helpers for the ALU adder path.
//   ALU_WIDTH   : default operand width
//   CLA_GROUP   : bits per first-level lookahead group
//   cla_carries : flattened 4-bit lookahead carries from bit g/p and a carry-in
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int CLA_GROUP = 4;

    // Returns the carry out of each of the four bits, so bit j of the result
    // is the carry into bit j+1. Every term is a sum of products taken
    // directly from g/p/cin, with no term built from another carry.
    function automatic logic [3:0] cla_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [3:0] c;
        c[0] = g[0]
             | (p[0] & cin);
        c[1] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[2] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// ---------------------------------------------------------------------------
// cla_group4
// First-level 4-bit carry-lookahead group.
// Ports:
//   i_g, i_p : bit generate / propagate for the four bits of the group
//   i_cin    : carry into the lowest bit of the group
//   o_c      : carries out of bits 0..2 (the group's internal carries)
//   o_cout   : carry out of bit 3 (group carry-out)
//   o_gg     : group generate (group produces a carry regardless of i_cin)
//   o_gp     : group propagate (all four bits propagate)
// ---------------------------------------------------------------------------
module cla_group4
    import alu_pkg::*;
(
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_cin,
    output logic [2:0] o_c,
    output logic       o_cout,
    output logic       o_gg,
    output logic       o_gp
);

    logic [3:0] w_c;

    assign w_c    = cla_carries(i_g, i_p, i_cin);
    assign o_c    = w_c[2:0];
    assign o_cout = w_c[3];

    assign o_gg = i_g[3]
                | (i_p[3] & i_g[2])
                | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_gp = &i_p;

endmodule

// File: rtl/big_carry_gen.sv
// ---------------------------------------------------------------------------
// big_carry_gen
// Two-level carry-lookahead carry generator for the ALU adder path.
// Ports:
//   clk, rst_n : clock and async active-low reset (registered outputs only)
//   a, b, cin  : operands and carry-in of a + b + cin
//   cout       : combinational carry-out (bit WIDTH of the full sum)
//   carries    : combinational carry out of every bit; carries[WIDTH-1]==cout
//   blk_g      : combinational block generate (a + b alone overflows)
//   blk_p      : combinational block propagate ((a ^ b) is all ones)
//   cout_q, blk_g_q, blk_p_q : registered copies, 1-cycle latency
// WIDTH must be a multiple of GROUP, and GROUP must be 4 (cla_group4).
// ---------------------------------------------------------------------------
module big_carry_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] carries,
    output logic             blk_g,
    output logic             blk_p,
    output logic             cout_q,
    output logic             blk_g_q,
    output logic             blk_p_q
);

    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP-1:0]  w_grp_cin;
    logic             w_blk_g;
    logic             w_blk_p;
    logic             w_cout;

    logic             r_cout;
    logic             r_blk_g;
    logic             r_blk_p;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Second-level lookahead: carry into group k as a flat sum of products
    // over the group generate/propagate terms below it, never chaining
    // through another group's carry.
    function automatic logic grp_lookahead(
        input logic [NGRP-1:0] gg,
        input logic [NGRP-1:0] gp,
        input logic            c_in,
        input int              k
    );
        logic result;
        logic term;
        result = c_in;
        for (int j = 0; j < k; j++) begin
            result = result & gp[j];
        end
        for (int j = 0; j < k; j++) begin
            term = gg[j];
            for (int m = j + 1; m < k; m++) begin
                term = term & gp[m];
            end
            result = result | term;
        end
        return result;
    endfunction

    always_comb begin
        w_grp_cin = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_grp_cin[k] = grp_lookahead(w_gg, w_gp, cin, k);
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [2:0] w_c_int;
        logic       w_c_out;

        cla_group4 u_grp (
            .i_g    (w_g[k*GROUP +: GROUP]),
            .i_p    (w_p[k*GROUP +: GROUP]),
            .i_cin  (w_grp_cin[k]),
            .o_c    (w_c_int),
            .o_cout (w_c_out),
            .o_gg   (w_gg[k]),
            .o_gp   (w_gp[k])
        );

        assign carries[k*GROUP +: GROUP] = {w_c_out, w_c_int};
    end

    // Block generate is the lookahead across all groups with no carry-in.
    assign w_blk_g = grp_lookahead(w_gg, w_gp, 1'b0, NGRP);
    assign w_blk_p = &w_gp;
    assign w_cout  = w_blk_g | (w_blk_p & cin);

    assign cout  = w_cout;
    assign blk_g = w_blk_g;
    assign blk_p = w_blk_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout  <= 1'b0;
            r_blk_g <= 1'b0;
            r_blk_p <= 1'b0;
        end else begin
            r_cout  <= w_cout;
            r_blk_g <= w_blk_g;
            r_blk_p <= w_blk_p;
        end
    end

    assign cout_q  = r_cout;
    assign blk_g_q = r_blk_g;
    assign blk_p_q = r_blk_p;

endmodule

// File: tb/tb_big_carry_gen.sv
// ---------------------------------------------------------------------------
// tb_big_carry_gen
// Directed checks of the combinational carry outputs, an exhaustive sweep
// against an arithmetic reference, and the registered/reset behaviour.
// ---------------------------------------------------------------------------
module tb_big_carry_gen;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       cout;
    logic [7:0] carries;
    logic       blk_g;
    logic       blk_p;
    logic       cout_q;
    logic       blk_g_q;
    logic       blk_p_q;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    big_carry_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .cout    (cout),
        .carries (carries),
        .blk_g   (blk_g),
        .blk_p   (blk_p),
        .cout_q  (cout_q),
        .blk_g_q (blk_g_q),
        .blk_p_q (blk_p_q)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a   = av;
        b   = bv;
        cin = cv;
    endtask

    // Arithmetic reference: carry out of bit i is bit i+1 of the sum of the
    // low i+1 bits of each operand plus cin.
    function automatic logic [10:0] ref_vec(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0]  s;
        logic [7:0]  c;
        logic [9:0]  part;
        logic [8:0]  mask;
        logic        g;
        logic        p;
        for (int i = 0; i < 8; i++) begin
            mask = (9'd1 << (i + 1)) - 9'd1;
            part = {1'b0, ({1'b0, av} & mask)} + {1'b0, ({1'b0, bv} & mask)} + {9'd0, cv};
            c[i] = part[i + 1];
        end
        s = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        g = ({1'b0, av} + {1'b0, bv}) > 9'd255;
        p = ((av ^ bv) == 8'hFF);
        return {s[8], g, p, c};
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        #2;

        // Reset state of the registered outputs
        check("rst_cout_q",  {31'd0, cout_q},  32'd0);
        check("rst_blk_g_q", {31'd0, blk_g_q}, 32'd0);
        check("rst_blk_p_q", {31'd0, blk_p_q}, 32'd0);

        // Full propagate chain
        drive(8'hFF, 8'h00, 1'b1); #1;
        check("prop_cout",    {31'd0, cout},    32'd1);
        check("prop_carries", {24'd0, carries}, 32'hFF);
        check("prop_blk_p",   {31'd0, blk_p},   32'd1);
        check("prop_blk_g",   {31'd0, blk_g},   32'd0);

        // MSB generate only
        drive(8'h80, 8'h80, 1'b0); #1;
        check("msb_cout",    {31'd0, cout},    32'd1);
        check("msb_carries", {24'd0, carries}, 32'h80);
        check("msb_blk_g",   {31'd0, blk_g},   32'd1);
        check("msb_blk_p",   {31'd0, blk_p},   32'd0);

        // Chain stopping one short of the top
        drive(8'h7F, 8'h00, 1'b1); #1;
        check("7f_cout",    {31'd0, cout},    32'd0);
        check("7f_carries", {24'd0, carries}, 32'h7F);

        // Complementary halves: carry only with cin
        drive(8'h0F, 8'hF0, 1'b0); #1;
        check("0ff0_c0_cout",    {31'd0, cout},    32'd0);
        check("0ff0_c0_carries", {24'd0, carries}, 32'h00);
        drive(8'h0F, 8'hF0, 1'b1); #1;
        check("0ff0_c1_cout",    {31'd0, cout},    32'd1);
        check("0ff0_c1_carries", {24'd0, carries}, 32'hFF);

        // Exhaustive sweep of {a, b, cin}
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    drive(ai[7:0], bi[7:0], ci[0]);
                    #1;
                    check($sformatf("sweep_a%02h_b%02h_c%0d", ai[7:0], bi[7:0], ci),
                          {21'd0, cout, blk_g, blk_p, carries},
                          {21'd0, ref_vec(ai[7:0], bi[7:0], ci[0])});
                end
            end
        end

        // Registered outputs held at zero throughout reset
        check("hold_rst_cout_q", {31'd0, cout_q}, 32'd0);

        // Release reset between edges and apply an overflowing vector
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'hFF, 8'h01, 1'b0);
        #1;
        check("pre_edge_cout_q",  {31'd0, cout_q},  32'd0);
        check("pre_edge_blk_g_q", {31'd0, blk_g_q}, 32'd0);
        @(posedge clk); #1;
        check("edge1_cout_q",  {31'd0, cout_q},  32'd1);
        check("edge1_blk_g_q", {31'd0, blk_g_q}, 32'd1);
        check("edge1_blk_p_q", {31'd0, blk_p_q}, 32'd0);

        // Propagate-only vector through the register
        @(negedge clk);
        drive(8'h0F, 8'hF0, 1'b0);
        @(posedge clk); #1;
        check("edge2_cout_q",  {31'd0, cout_q},  32'd0);
        check("edge2_blk_g_q", {31'd0, blk_g_q}, 32'd0);
        check("edge2_blk_p_q", {31'd0, blk_p_q}, 32'd1);

        // Back to a carry-out so the register holds 1
        @(negedge clk);
        drive(8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        check("edge3_cout_q", {31'd0, cout_q}, 32'd1);

        // Mid-operation reset between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cout_q",  {31'd0, cout_q},  32'd0);
        check("midrst_blk_g_q", {31'd0, blk_g_q}, 32'd0);
        check("midrst_cout",    {31'd0, cout},    32'd1);
        @(posedge clk); #1;
        check("midrst_hold_cout_q", {31'd0, cout_q}, 32'd0);

        // Recapture after release
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("recap_cout_q", {31'd0, cout_q}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
